// File: rtl/work_dispatch_pkg.sv
// work_pkg: command codes, dispatcher states and write-region selectors
package work_pkg;
  localparam logic [7:0] CMD_LOAD_HDR = 8'h01;
  localparam logic [7:0] CMD_LOAD_TGT = 8'h02;
  localparam logic [7:0] CMD_START    = 8'h03;
  localparam logic [7:0] CMD_ABORT    = 8'h04;
  localparam logic [7:0] CMD_CLR_ERR  = 8'h05;
  localparam logic REGION_HDR = 1'b0;
  localparam logic REGION_TGT = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_HDR, ST_LOAD_TGT} dispatch_state_t;
endpackage

// File: rtl/work_dispatch_if.sv
// work_dispatch_if: transceiver byte stream, scrypt core control and work-memory write port
interface work_dispatch_if #(parameter int ADDR_W = 7);
  logic              notify;
  logic [7:0]        command;
  logic [7:0]        rx_out;
  logic              core_busy;
  logic              core_found;
  logic [31:0]       core_nonce;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              core_start;
  logic              core_abort;
  logic              nonce_ready;
  logic [31:0]       nonce;
  logic              load_err;
  modport master (
    output notify, command, rx_out, core_busy, core_found, core_nonce,
    input  wr_en, wr_sel, wr_addr, wr_data, core_start, core_abort, nonce_ready, nonce, load_err
  );
  modport slave (
    input  notify, command, rx_out, core_busy, core_found, core_nonce,
    output wr_en, wr_sel, wr_addr, wr_data, core_start, core_abort, nonce_ready, nonce, load_err
  );
endinterface

// File: rtl/work_dispatch_load_timeout.sv
// load_timeout: idle-cycle down-counter, reloaded by clr_i, pulses tick_o when it expires
module load_timeout #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d  = clr_i ? W'(CYCLES - 1) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    tick_o = en_i && !clr_i && cnt_q == '0;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/work_dispatch.sv
// work_dispatch: decodes host command bytes, streams work bytes to the core, latches found nonces
module work_dispatch
  import work_pkg::*;
#(
  parameter int HDR_BYTES      = 76,
  parameter int TGT_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ADDR_W         = 7
) (
  input logic           clk,
  input logic           n_rst,
  work_dispatch_if.slave bus
);
  dispatch_state_t   state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d, wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [31:0]       nonce_q, nonce_d;
  logic wr_en_q, wr_en_d, wr_sel_q, wr_sel_d, start_q, start_d, abort_q, abort_d;
  logic ready_q, ready_d, err_q, err_d;
  logic loading, last, region, timeout, unused_cmd;
  assign unused_cmd = ^bus.command;
  assign loading = state_q != ST_IDLE;
  assign region  = (state_q == ST_LOAD_TGT) ? REGION_TGT : REGION_HDR;
  assign last    = byte_cnt_q == ((state_q == ST_LOAD_HDR) ? ADDR_W'(HDR_BYTES - 1) : ADDR_W'(TGT_BYTES - 1));
  load_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (bus.notify || !loading),
    .en_i  (loading),
    .tick_o(timeout)
  );
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    err_d      = err_q;
    nonce_d    = bus.core_found ? bus.core_nonce : nonce_q;
    ready_d    = bus.core_found | ready_q;
    if (bus.notify && !loading) begin
      case (bus.rx_out)
        CMD_LOAD_HDR: begin state_d = ST_LOAD_HDR; byte_cnt_d = '0; end
        CMD_LOAD_TGT: begin state_d = ST_LOAD_TGT; byte_cnt_d = '0; end
        CMD_START:    begin start_d = !bus.core_busy; err_d = err_q | bus.core_busy; end
        CMD_ABORT:    abort_d = 1'b1;
        CMD_CLR_ERR:  err_d = 1'b0;
        default:      err_d = 1'b1;
      endcase
    end else if (bus.notify) begin
      wr_en_d    = 1'b1;
      wr_sel_d   = region;
      wr_addr_d  = byte_cnt_q;
      wr_data_d  = bus.rx_out;
      byte_cnt_d = byte_cnt_q + 1'b1;
      state_d    = last ? ST_IDLE : state_q;
    end else if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    // a clearing command beats a simultaneous core_found: that nonce is dropped
    if (start_d || abort_d) begin
      ready_d = 1'b0;
      nonce_d = start_d ? '0 : nonce_q;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      ready_q    <= 1'b0;
      nonce_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      ready_q    <= ready_d;
      nonce_q    <= nonce_d;
      err_q      <= err_d;
    end
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_sel      = wr_sel_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.core_start  = start_q;
  assign bus.core_abort  = abort_q;
  assign bus.nonce_ready = ready_q;
  assign bus.nonce       = nonce_q;
  assign bus.load_err    = err_q;
endmodule

// File: tb/tb_work_dispatch.sv
// tb_work_dispatch: scoreboard bench; stimulus queues expected write/start/abort events, a monitor checks them
module tb_work_dispatch;
  localparam int K_WR = 0, K_START = 1, K_ABORT = 2, K_NONE = -1;
  typedef struct {
    int         kind;
    logic       sel;
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  q[$];
  work_dispatch_if #(.ADDR_W(7)) bus();
  work_dispatch #(.HDR_BYTES(76), .TGT_BYTES(32), .TIMEOUT_CYCLES(100), .ADDR_W(7)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic got(input int k, input logic s, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d sel=%0d addr=%0d data=%h cyc=%0d, expected none", k, s, a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == K_WR && (e.sel !== s || e.addr !== a || e.data !== d))) begin
        n_err++;
        $display("FAIL event: got kind=%0d sel=%0d addr=%0d data=%h cyc=%0d, expected kind=%0d sel=%0d addr=%0d data=%h cyc=%0d",
                 k, s, a, d, cyc, e.kind, e.sel, e.addr, e.data, e.cyc);
      end
    end
  endtask
  always @(negedge clk)
    if (n_rst) begin
      if (bus.wr_en)      got(K_WR, bus.wr_sel, bus.wr_addr, bus.wr_data);
      if (bus.core_start) got(K_START, 1'b0, 7'd0, 8'd0);
      if (bus.core_abort) got(K_ABORT, 1'b0, 7'd0, 8'd0);
    end
  task automatic send(input logic [7:0] b, input int kind, input logic sel, input logic [6:0] addr);
    @(posedge clk) #1;
    bus.notify = 1'b1;
    bus.rx_out = b;
    if (kind != K_NONE) q.push_back('{kind, sel, addr, b, cyc + 1});
    @(posedge clk) #1;
    bus.notify = 1'b0;
    repeat (8) @(posedge clk);
  endtask
  task automatic found(input logic [31:0] n);
    @(posedge clk) #1;
    bus.core_found = 1'b1;
    bus.core_nonce = n;
    @(posedge clk) #1;
    bus.core_found = 1'b0;
  endtask
  initial begin
    logic [7:0] b;
    bus.notify = 1'b0; bus.command = 8'h00; bus.rx_out = 8'h00;
    bus.core_busy = 1'b0; bus.core_found = 1'b0; bus.core_nonce = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, bus.wr_en}, 0);
    chk("rst_start", {31'd0, bus.core_start}, 0);
    chk("rst_nonce_ready", {31'd0, bus.nonce_ready}, 0);
    chk("rst_load_err", {31'd0, bus.load_err}, 0);
    @(negedge clk) n_rst = 1'b1;
    // header load: data equals address
    send(8'h01, K_NONE, 1'b0, 7'd0);
    for (int i = 0; i < 76; i++) send(8'(i), K_WR, 1'b0, 7'(i));
    chk("hdr_load_err", {31'd0, bus.load_err}, 0);
    // target load with a command-valued data byte
    send(8'h02, K_NONE, 1'b0, 7'd0);
    for (int i = 0; i < 32; i++) begin
      b = (i == 5) ? 8'h03 : 8'(8'h80 + i);
      send(b, K_WR, 1'b1, 7'(i));
    end
    chk("tgt_load_err", {31'd0, bus.load_err}, 0);
    // start, then nonce capture (latest wins)
    send(8'h03, K_START, 1'b0, 7'd0);
    chk("start_clears_ready", {31'd0, bus.nonce_ready}, 0);
    found(32'hDEADBEEF);
    chk("found_ready", {31'd0, bus.nonce_ready}, 1);
    chk("found_nonce", bus.nonce, 32'hDEADBEEF);
    found(32'h12345678);
    chk("found2_nonce", bus.nonce, 32'h12345678);
    // timeout after 10 bytes
    send(8'h01, K_NONE, 1'b0, 7'd0);
    for (int i = 0; i < 10; i++) send(8'(8'h40 + i), K_WR, 1'b0, 7'(i));
    repeat (150) @(posedge clk);
    #1;
    chk("timeout_err", {31'd0, bus.load_err}, 1);
    send(8'h05, K_NONE, 1'b0, 7'd0);
    chk("clr_err", {31'd0, bus.load_err}, 0);
    // start while busy is rejected
    bus.core_busy = 1'b1;
    send(8'h03, K_NONE, 1'b0, 7'd0);
    chk("busy_start_err", {31'd0, bus.load_err}, 1);
    chk("busy_keeps_ready", {31'd0, bus.nonce_ready}, 1);
    bus.core_busy = 1'b0;
    // abort with a simultaneous core_found: clear wins
    @(posedge clk) #1;
    bus.notify = 1'b1; bus.rx_out = 8'h04;
    bus.core_found = 1'b1; bus.core_nonce = 32'hCAFEF00D;
    q.push_back('{K_ABORT, 1'b0, 7'd0, 8'h04, cyc + 1});
    @(posedge clk) #1;
    bus.notify = 1'b0; bus.core_found = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ready", {31'd0, bus.nonce_ready}, 0);
    chk("abort_nonce_kept", bus.nonce, 32'h12345678);
    send(8'h05, K_NONE, 1'b0, 7'd0);
    send(8'h07, K_NONE, 1'b0, 7'd0);
    chk("bad_cmd_err", {31'd0, bus.load_err}, 1);
    // async reset mid header load
    send(8'h01, K_NONE, 1'b0, 7'd0);
    for (int i = 0; i < 40; i++) send(8'(8'hA0 + i), K_WR, 1'b0, 7'(i));
    @(negedge clk) #2;
    n_rst = 1'b0;
    #1;
    chk("rstmid_wr_addr", {25'd0, bus.wr_addr}, 0);
    chk("rstmid_wr_data", {24'd0, bus.wr_data}, 0);
    chk("rstmid_nonce", bus.nonce, 0);
    chk("rstmid_load_err", {31'd0, bus.load_err}, 0);
    chk("rstmid_ctrl", {28'd0, bus.wr_en, bus.wr_sel, bus.core_start, bus.core_abort}, 0);
    @(negedge clk) n_rst = 1'b1;
    send(8'h02, K_NONE, 1'b0, 7'd0);
    for (int i = 0; i < 32; i++) send(8'(8'h10 + i), K_WR, 1'b1, 7'(i));
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/work_dispatch.md
Name: work_dispatch

Overview:
- Sits directly downstream of the I2C slave transceiver. Consumes its per-byte `notify` / `command` / `rx_out` stream and interprets host write traffic as a small command protocol.
- Streams header and target bytes into the scrypt core's work memory and pulses start/abort to the core.
- Upstream direction: latches the core's found nonce and presents it to the transceiver as `nonce_ready` / `nonce` for the host to read back.

Parameters:
- HDR_BYTES, 76, header bytes loaded per work unit (80-byte header minus 4-byte nonce)
- TGT_BYTES, 32, target bytes loaded per LOAD_TARGET
- TIMEOUT_CYCLES, 1_000_000, idle clocks mid-load before the load is aborted
- ADDR_W, 7, width of work-memory byte address

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- notify  in  1  one-cycle pulse per byte received from host
- command  in  8  first data byte of current I2C write (informational only)
- rx_out  in  8  byte received, valid when notify=1
- core_busy  in  1  scrypt core is hashing
- core_found  in  1  one-cycle pulse: core found a nonce
- core_nonce  in  32  nonce valid with core_found
- wr_en  out  1  work-memory byte write strobe
- wr_sel  out  1  0=header region, 1=target region
- wr_addr  out  ADDR_W  byte index within region
- wr_data  out  8  byte to write
- core_start  out  1  one-cycle start pulse
- core_abort  out  1  one-cycle abort pulse
- nonce_ready  out  1  found nonce valid for readback
- nonce  out  32  found nonce (byte 0 = MSB, matches transceiver readback order)
- load_err  out  1  sticky: load timed out or command rejected

Behaviour:
- Reset: state=IDLE. All outputs 0. Counters 0.
- Command codes, taken from rx_out on a notify in IDLE: 0x01 LOAD_HDR, 0x02 LOAD_TGT, 0x03 START, 0x04 ABORT, 0x05 CLR_ERR. Any other code sets load_err; state stays IDLE.
- FSM states: IDLE, LOAD_HDR, LOAD_TGT.
- IDLE + 0x01 -> LOAD_HDR, byte_cnt=0.
- IDLE + 0x02 -> LOAD_TGT, byte_cnt=0.
- IDLE + 0x03:
  - if core_busy=0: core_start=1 for one cycle the next clock; nonce_ready and nonce are cleared in the same cycle.
  - if core_busy=1: ignored, load_err set.
- IDLE + 0x04: core_abort=1 for one cycle the next clock; nonce_ready cleared.
- IDLE + 0x05: load_err cleared.
- LOAD_* on notify:
  - registered write one clock later: wr_en=1, wr_sel=region, wr_addr=byte_cnt, wr_data=rx_out.
  - byte_cnt increments.
  - on byte_cnt = N-1 (N=HDR_BYTES or TGT_BYTES) the FSM returns to IDLE after issuing that write.
- In LOAD_* every byte is data, including values equal to command codes.
- Timeout:
  - idle counter resets on each notify; it counts only in LOAD_* states.
  - on reaching TIMEOUT_CYCLES-1: -> IDLE, load_err=1, no write issued.
  - bytes already written are not rolled back.
- Loading while core_busy=1 is permitted; the core owns double-buffering.
- Nonce capture:
  - core_found=1: nonce<=core_nonce, nonce_ready<=1, held until the next START/ABORT.
  - a second core_found overwrites the nonce (latest wins).
- Simultaneous core_found with the cycle clearing nonce_ready: clear wins, found nonce dropped.
- notify while a write is still pending cannot occur (min 9 SCL bits between bytes); no back-pressure.
- Latency: notify -> wr_en 1 cycle; command -> start/abort 1 cycle.
- Reset mid-load: async return to IDLE, partial load discarded by the host protocol.

Decomposition:
- Package `work_pkg`:
  - command-code localparams (CMD_LOAD_HDR..CMD_CLR_ERR)
  - state enum `dispatch_state_t`
  - region constants REGION_HDR/REGION_TGT
- One natural sub-module, `load_timeout`: loadable down-counter with clear, enable, and a terminal pulse. Everything else lives in work_dispatch.

Test Plan:
- Send 0x01 then 76 bytes 0x00..0x4B at 10 clk spacing -> 76 wr_en pulses, wr_sel=0, wr_addr 0..75, wr_data=addr; state IDLE afterwards; load_err=0.
- Send 0x02 then 32 bytes, with byte 5 = 0x03 -> 32 target writes, wr_data[5]=0x03; no core_start pulse.
- core_busy=0, send 0x03 -> core_start high exactly 1 cycle, 1 clk after notify. Then core_found with core_nonce=0xDEADBEEF -> nonce_ready=1, nonce=0xDEADBEEF.
- Send 0x01, 10 bytes, then silence for TIMEOUT_CYCLES (set to 100) -> IDLE, load_err=1, no 11th write. Then 0x05 -> load_err=0.
- core_busy=1, send 0x03 -> no core_start, load_err=1. Send 0x04 -> core_abort 1 cycle, nonce_ready cleared.
- Assert n_rst low mid header load at byte 40 -> all outputs 0 immediately. Then 0x02 + 32 bytes -> writes start at wr_addr 0.
